axis_image_rx_checker: RTL and testbench

Synthesizable AXI-Stream image receiver, the consuming end of the 8-bit pixel stream driven by the DPI source model. It accepts pixels under valid/ready, with optional pseudo-random backpressure. It tracks line and frame geometry, checks `last` placement, and reports a per-frame checksum and status. It lets the bench exercise source backpressure handling in RTL instead of the DPI sink.

---
 rtl/axis_image_rx_checker_if.sv | 12 +
 rtl/axis_image_rx_checker.sv | 150 +++++++++++++++
 tb/tb_axis_image_rx_checker.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_image_rx_checker_if.sv
// AXI-Stream style pixel bus between an image source and the receiver/checker.
interface axis_image_rx_checker_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_image_rx_checker.sv
// Image stream receiver: accepts pixels with optional LFSR backpressure,
// tracks line/frame geometry, flags misplaced `last` and reports a per-frame
// checksum, status and frame count.
module axis_image_rx_checker #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IMG_W     = 64,
  parameter int unsigned IMG_H     = 48,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  axis_image_rx_checker_if.slave    s_axis,
  input  logic                      stall_en,
  output logic                      frame_done,
  output logic                      frame_ok,
  output logic                      err_early_last,
  output logic                      err_missing_last,
  output logic [15:0]               checksum,
  output logic [15:0]               frame_count
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [15:0]       acc_q, acc_d;
  logic              early_q, early_d;
  logic              missing_q, missing_d;
  logic              fd_q, fd_d;
  logic              ok_q, ok_d;
  logic [15:0]       cks_q, cks_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0] pix;
  logic              xfer;
  logic              at_x_max;
  logic              line_end;
  logic              lfsr_fb;

  assign pix      = s_axis.data;
  assign xfer     = s_axis.valid & ready_q;
  assign at_x_max = (x_q == X_MAX);
  assign line_end = s_axis.last | at_x_max;
  assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // Next-state logic: FSM, geometry counters, accumulator and frame results
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    early_d   = early_q;
    missing_d = missing_q;
    fd_d      = 1'b0;
    ok_d      = ok_q;
    cks_d     = cks_q;
    cnt_d     = cnt_q;
    lfsr_d    = {lfsr_fb, lfsr_q[15:1]};

    case (state_q)
      ST_IDLE: state_d = ST_RECV;
      ST_RECV: begin
        if (xfer) begin
          acc_d = acc_q + 16'(pix);
          x_d   = x_q + 1'b1;
          if (line_end) begin
            x_d = '0;
            if (s_axis.last && !at_x_max) early_d = 1'b1;
            if (at_x_max && !s_axis.last) missing_d = 1'b1;
            if (y_q == Y_MAX) begin
              // Results are latched here, including the final beat, so they
              // are already visible during the single DONE cycle.
              state_d = ST_DONE;
              fd_d    = 1'b1;
              ok_d    = ~(early_d | missing_d);
              cks_d   = acc_d;
              cnt_d   = cnt_q + 16'd1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_RECV;
        acc_d     = '0;
        early_d   = 1'b0;
        missing_d = 1'b0;
        x_d       = '0;
        y_d       = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered and only ever high while the next state is RECV
  always_comb begin
    ready_d = (state_d == ST_RECV) & (~stall_en | lfsr_q[0]);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
      fd_q      <= 1'b0;
      ok_q      <= 1'b0;
      cks_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      lfsr_q    <= lfsr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      early_q   <= early_d;
      missing_q <= missing_d;
      fd_q      <= fd_d;
      ok_q      <= ok_d;
      cks_q     <= cks_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_axis.ready     = ready_q;
  assign frame_done       = fd_q;
  assign frame_ok         = ok_q;
  assign err_early_last   = early_q;
  assign err_missing_last = missing_q;
  assign checksum         = cks_q;
  assign frame_count      = cnt_q;

endmodule

// File: tb/tb_axis_image_rx_checker.sv
// Scoreboard bench for axis_image_rx_checker with a 4x2 image.
module tb_axis_image_rx_checker;
  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_en = 1'b0;
  logic        frame_done, frame_ok, err_early_last, err_missing_last;
  logic [15:0] checksum, frame_count;

  axis_image_rx_checker_if #(.DATA_W(8)) s_axis ();

  always #5 clk = ~clk;

  axis_image_rx_checker #(
    .DATA_W(8),
    .IMG_W(W),
    .IMG_H(H),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis(s_axis),
    .stall_en(stall_en),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .err_early_last(err_early_last),
    .err_missing_last(err_missing_last),
    .checksum(checksum),
    .frame_count(frame_count)
  );

  typedef struct {
    logic        ok;
    logic        early;
    logic        missing;
    logic [15:0] cks;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  logic        prev_fd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every frame_done pulse is matched against the next expected frame
  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      chk("fd_one_cycle", prev_fd, 0);
      chk("ready_low_in_done", s_axis.ready, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        chk("frame_ok", frame_ok, mon_e.ok);
        chk("err_early_last", err_early_last, mon_e.early);
        chk("err_missing_last", err_missing_last, mon_e.missing);
        chk("checksum", checksum, mon_e.cks);
        chk("frame_count", frame_count, mon_e.cnt);
      end
    end
    prev_fd <= rst_n & frame_done;
  end

  task automatic push_exp(input logic ok, input logic early, input logic missing,
                          input logic [15:0] cks);
    exp_t e;
    exp_cnt   = exp_cnt + 16'd1;
    e.ok      = ok;
    e.early   = early;
    e.missing = missing;
    e.cks     = cks;
    e.cnt     = exp_cnt;
    sb.push_back(e);
  endtask

  // Called at a negedge; holds the beat until ready, returns after its transfer edge
  task automatic send_beat(input logic [7:0] d, input logic l, output int unsigned waits);
    s_axis.data  = d;
    s_axis.last  = l;
    s_axis.valid = 1'b1;
    waits = 0;
    while (!s_axis.ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] pv, input logic [7:0] lm, input int n,
                            output int unsigned mid_waits, output int unsigned all_waits);
    int unsigned w;
    mid_waits = 0;
    all_waits = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(pv[8*i +: 8], lm[i], w);
      all_waits += w;
      if (i > 0) mid_waits += w;
    end
    s_axis.valid = 1'b0;
    s_axis.last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    s_axis.valid = 1'b0;
    s_axis.last  = 1'b0;
    @(negedge clk);
    chk("rst_ready", s_axis.ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_err_early", err_early_last, 0);
    chk("rst_err_missing", err_missing_last, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_frame_count", frame_count, 0);
    exp_cnt = '0;
    rst_n   = 1'b1;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] fill(input int unsigned base, input bit constant);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = constant ? 8'(base) : 8'(base + i);
    return v;
  endfunction

  initial begin
    int unsigned mid, all;
    s_axis.valid = 1'b0;
    s_axis.data  = '0;
    s_axis.last  = 1'b0;

    do_reset();

    // Clean frame, pixels 1..8, last on beats 4 and 8
    push_exp(1'b1, 1'b0, 1'b0, 16'd36);
    send_frame(fill(1, 0), 8'b1000_1000, 8, mid, all);
    chk("t1_ready_held", mid, 0);
    wait_drain();
    chk("t1_checksum_hold", checksum, 36);
    chk("t1_count_hold", frame_count, 1);

    // Early last on beat 2 ends line 0; line 1 ends on beat 6 (x==3 with last)
    push_exp(1'b0, 1'b1, 1'b0, 16'd21);
    send_frame(fill(1, 0), 8'b0010_0010, 6, mid, all);
    wait_drain();

    // No last at all: both lines count-terminated
    push_exp(1'b0, 1'b0, 1'b1, 16'd36);
    send_frame(fill(1, 0), 8'b0000_0000, 8, mid, all);
    wait_drain();
    chk("t3_flags_cleared", err_missing_last, 0);

    // LFSR backpressure with valid held
    do_reset();
    stall_en = 1'b1;
    push_exp(1'b1, 1'b0, 1'b0, 16'd36);
    send_frame(fill(1, 0), 8'b1000_1000, 8, mid, all);
    chk("t4_stalls_seen", (all > 0), 1);
    wait_drain();
    stall_en = 1'b0;

    // Back-to-back frames of 255s
    do_reset();
    push_exp(1'b1, 1'b0, 1'b0, 16'd2040);
    send_frame(fill(255, 1), 8'b1000_1000, 8, mid, all);
    push_exp(1'b1, 1'b0, 1'b0, 16'd2040);
    send_frame(fill(255, 1), 8'b1000_1000, 8, mid, all);
    wait_drain();
    chk("t5_count", frame_count, 2);

    // Partial frame discarded by reset, then a clean frame
    send_frame(fill(1, 0), 8'b0000_1000, 5, mid, all);
    do_reset();
    push_exp(1'b1, 1'b0, 1'b0, 16'd36);
    send_frame(fill(1, 0), 8'b1000_1000, 8, mid, all);
    wait_drain();
    chk("t6_count", frame_count, 1);
    chk("t6_checksum", checksum, 36);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
